// File: rtl/seg_readback.sv
// Readback decoder for the multiplexed 7-segment bus.
// Debounces per-position patterns, decodes them to codes and flags blinking.
module seg_readback #(
  parameter int NPOS      = 6,
  parameter int STABLE_N  = 4,
  parameter int BLINK_WIN = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_valid,
  input  logic [6:0] seg,
  input  logic [2:0] seg_pos,
  input  logic [2:0] rd_pos,
  output logic [3:0] rd_code,
  output logic [3:0] rd_glyph,
  output logic       rd_blink,
  output logic       upd,
  output logic [2:0] upd_pos,
  output logic       err,
  input  logic       err_clr
);

  localparam int TW = $clog2(BLINK_WIN + 1);
  localparam logic [TW-1:0] TMAX = TW'(BLINK_WIN);
  localparam logic [3:0] SN = 4'(STABLE_N);
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] INVAL = 4'hE;

  logic [3:0]    com_q [NPOS];
  logic [3:0]    com_d [NPOS];
  logic [3:0]    gly_q [NPOS];
  logic [3:0]    gly_d [NPOS];
  logic [3:0]    cand_q [NPOS];
  logic [3:0]    cand_d [NPOS];
  logic [3:0]    cnt_q [NPOS];
  logic [3:0]    cnt_d [NPOS];
  logic [TW-1:0] tmr_q [NPOS];
  logic [TW-1:0] tmr_d [NPOS];
  logic          blk_q [NPOS];
  logic          blk_d [NPOS];
  logic          upd_q, upd_d;
  logic [2:0]    upd_pos_q, upd_pos_d;
  logic          err_q, err_d;

  logic [3:0] code;
  logic       in_rng;
  logic       err_set;
  logic       hit;
  logic       commit;
  logic       bb;

  always_comb begin
    case (seg)
      7'b1111110: code = 4'd0;
      7'b0110000: code = 4'd1;
      7'b1101101: code = 4'd2;
      7'b1111001: code = 4'd3;
      7'b0110011: code = 4'd4;
      7'b1011011: code = 4'd5;
      7'b1011111: code = 4'd6;
      7'b1110000: code = 4'd7;
      7'b1111111: code = 4'd8;
      7'b1111011: code = 4'd9;
      7'b1110111: code = 4'd10;
      7'b1100111: code = 4'd11;
      7'b0000001: code = 4'd12;
      7'b0000000: code = BLANK;
      default:    code = INVAL;
    endcase
  end

  always_comb begin
    com_d     = com_q;
    gly_d     = gly_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    blk_d     = blk_q;
    upd_d     = 1'b0;
    upd_pos_d = upd_pos_q;
    hit       = 1'b0;
    commit    = 1'b0;
    bb        = 1'b0;
    in_rng    = int'(seg_pos) < NPOS;
    err_set   = seg_valid && !in_rng;
    for (int i = 0; i < NPOS; i++) begin
      hit    = seg_valid && in_rng && (seg_pos == 3'(i));
      commit = 1'b0;
      if (hit) begin
        if (code == cand_q[i]) begin
          if (cnt_q[i] < SN) cnt_d[i] = cnt_q[i] + 4'd1;
          if (cnt_q[i] == SN - 4'd1 && code != com_q[i])
            commit = 1'b1;
        end else begin
          cand_d[i] = code;
          cnt_d[i]  = 4'd1;
        end
      end
      bb = commit && ((com_q[i] == BLANK) != (code == BLANK));
      tmr_d[i] = (tmr_q[i] < TMAX) ? tmr_q[i] + 1'b1 : tmr_q[i];
      // Blink is set only if the previous blank edge was recent.
      if (bb) begin
        if (tmr_q[i] < TMAX) blk_d[i] = 1'b1;
        tmr_d[i] = '0;
      end else if (tmr_d[i] == TMAX) begin
        blk_d[i] = 1'b0;
      end
      if (commit) begin
        com_d[i]  = code;
        if (code != BLANK) gly_d[i] = code;
        upd_d     = 1'b1;
        upd_pos_d = 3'(i);
        if (code == INVAL) err_set = 1'b1;
      end
    end
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPOS; i++) begin
        com_q[i]  <= BLANK;
        gly_q[i]  <= BLANK;
        cand_q[i] <= BLANK;
        cnt_q[i]  <= '0;
        tmr_q[i]  <= TMAX;
        blk_q[i]  <= 1'b0;
      end
      upd_q     <= 1'b0;
      upd_pos_q <= '0;
      err_q     <= 1'b0;
    end else begin
      com_q     <= com_d;
      gly_q     <= gly_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      blk_q     <= blk_d;
      upd_q     <= upd_d;
      upd_pos_q <= upd_pos_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    rd_code  = BLANK;
    rd_glyph = BLANK;
    rd_blink = 1'b0;
    for (int i = 0; i < NPOS; i++) begin
      if (rd_pos == 3'(i)) begin
        rd_code  = com_q[i];
        rd_glyph = gly_q[i];
        rd_blink = blk_q[i];
      end
    end
  end

  assign upd     = upd_q;
  assign upd_pos = upd_pos_q;
  assign err     = err_q;

endmodule
